mem_wb_reg: RTL and testbench
=============================

# mem_wb_reg

MEM/WB pipeline register of the five-stage pipeline. Captures the memory-stage result at each clock edge and extracts, aligns and sign/zero-extends load data from the raw data-memory word. Presents the two write-back candidates (ALU result, load data) plus the select to the write-back 2:1 mux, and the destination register and write enable to the register file. Tracks the HALT instruction retiring, supporting stall, flush and a sticky halted state.

## Interface
- NB_DATA, 32, datapath width (must be 32; byte-lane logic is fixed at 4 lanes)
- NB_REG_ADDR, 5, register-file address width
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  hold all outputs unchanged
- i_flush  in  1  load a bubble instead of the incoming instruction
- i_valid  in  1  incoming MEM-stage slot holds a real instruction
- i_alu_result  in  NB_DATA  ALU result / effective address from EX/MEM
- i_mem_rdata  in  NB_DATA  raw 32-bit word read from data memory
- i_mem_to_reg  in  1  0: write back ALU result, 1: write back load data
- i_reg_write  in  1  instruction writes the register file
- i_rd_addr  in  NB_REG_ADDR  destination register
- i_load_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- i_load_unsigned  in  1  1: zero-extend, 0: sign-extend (byte/half only)
- i_halt  in  1  incoming instruction is HALT
- o_alu_result  out  NB_DATA  registered ALU result (mux input A)
- o_load_data  out  NB_DATA  registered aligned/extended load data (mux input B)
- o_mem_to_reg  out  1  registered mux select
- o_reg_write  out  1  registered write enable, gated as below
- o_rd_addr  out  NB_REG_ADDR  registered destination
- o_valid  out  1  registered slot valid
- o_misaligned  out  1  registered: captured load was a misaligned halfword
- o_halted  out  1  sticky: HALT has retired

## Operation
- State machine, two states: RUN, HALTED. Reset -> RUN.
- Update priority per edge: i_reset > HALTED hold > i_flush > i_stall > capture.
- Reset: every output and state bit cleared to 0 (all data outputs 0, o_rd_addr 0).
- RUN, capture (no flush, no stall): all o_* <= corresponding inputs, with o_load_data and o_misaligned computed from i_mem_rdata, i_alu_result[1:0], i_load_size, i_load_unsigned.
- Alignment, little-endian, offset = i_alu_result[1:0]:
  - byte: lane = i_mem_rdata[8*offset+7 : 8*offset]; extend bit 7 of lane (signed) or zeros.
  - half: offset[1]=0 -> bits 15:0, offset[1]=1 -> bits 31:16; extend bit 15 or zeros; offset[0]=1 -> misaligned.
  - word / 11: i_mem_rdata unchanged; i_load_unsigned ignored; alignment not checked.
- Misaligned halfword with i_mem_to_reg=1: o_misaligned=1, o_reg_write forced 0, o_load_data still the offset[1]-selected extended half.
- o_reg_write = i_reg_write & i_valid & ~misaligned; o_valid = i_valid.
- Load data is computed regardless of i_mem_to_reg; o_misaligned only asserts when i_mem_to_reg=1.
- Flush: o_valid, o_reg_write, o_mem_to_reg, o_misaligned <= 0; o_alu_result, o_load_data, o_rd_addr <= 0; state unchanged.
- Stall: all outputs hold previous value.
- Capture with i_valid=1 and i_halt=1: state -> HALTED, o_halted <= 1 on the same edge; the HALT slot itself is captured with o_reg_write forced 0.
- HALTED: next edge and every edge after clears o_valid, o_reg_write, o_misaligned and holds other outputs; i_flush/i_stall/i_valid ignored; only i_reset leaves HALTED.
- i_halt with i_valid=0, or under flush/stall, has no effect.

## Timing
- Latency exactly 1 cycle from inputs to o_*; no combinational input-to-output path.
- Stall and flush both asserted: flush wins.
- Reset asserted mid-stall or in HALTED: outputs 0 and state RUN at the next edge.
- o_halted rises at the edge capturing HALT and stays 1 until reset.

## Test plan
- Reset: drive i_reset=1 one edge with nonzero inputs -> all outputs 0, o_halted=0.
- Loads from i_mem_rdata=0x80F1_7F82: byte signed offset 0 -> 0xFFFF_FF82; byte unsigned offset 3 -> 0x0000_0080; half signed offset 2 -> 0xFFFF_80F1; word -> 0x80F1_7F82; each 1 cycle later, o_reg_write=1.
- Misaligned: half load, i_alu_result=0x0000_1003, i_reg_write=1, i_mem_to_reg=1 -> o_misaligned=1, o_reg_write=0.
- Stall then flush: capture rd=7 ALU=0x1234, hold i_stall 3 edges -> outputs unchanged; assert i_stall and i_flush together -> o_valid=0, o_reg_write=0, o_rd_addr=0.
- Halt: valid HALT captured -> o_halted=1, o_reg_write=0; next cycle valid rd=3 write -> o_valid=0, o_reg_write=0; i_reset -> o_halted=0.
- Back-to-back: ALU-type (mem_to_reg=0, rd=1, 0xA) then load (rd=2) on consecutive edges -> outputs update every cycle with no bubble.

Source files
------------

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the memory-stage result, aligns and extends
// load data, and tracks HALT retirement with a sticky halted state.
module mem_wb_reg #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic [NB_DATA-1:0]     i_mem_rdata,
    input  logic                   i_mem_to_reg,
    input  logic                   i_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_rd_addr,
    input  logic [1:0]             i_load_size,
    input  logic                   i_load_unsigned,
    input  logic                   i_halt,
    output logic [NB_DATA-1:0]     o_alu_result,
    output logic [NB_DATA-1:0]     o_load_data,
    output logic                   o_mem_to_reg,
    output logic                   o_reg_write,
    output logic [NB_REG_ADDR-1:0] o_rd_addr,
    output logic                   o_valid,
    output logic                   o_misaligned,
    output logic                   o_halted
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]             r_state;
    logic [NB_DATA-1:0]     r_alu_result;
    logic [NB_DATA-1:0]     r_load_data;
    logic                   r_mem_to_reg;
    logic                   r_reg_write;
    logic [NB_REG_ADDR-1:0] r_rd_addr;
    logic                   r_valid;
    logic                   r_misaligned;

    logic [1:0]             w_offset;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [NB_DATA-1:0]     w_load_data;
    logic                   w_misaligned;
    logic                   w_halt_take;

    assign w_offset = i_alu_result[1:0];

    always_comb begin
        w_byte = i_mem_rdata[7:0];
        case (w_offset)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
    end

    assign w_half = w_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    // Load data is always formed; misalignment only matters for real loads.
    always_comb begin
        w_load_data  = i_mem_rdata;
        w_misaligned = 1'b0;
        case (i_load_size)
            2'b00: w_load_data = {{24{w_byte[7] & ~i_load_unsigned}}, w_byte};
            2'b01: begin
                w_load_data  = {{16{w_half[15] & ~i_load_unsigned}}, w_half};
                w_misaligned = w_offset[0] & i_mem_to_reg;
            end
            default: w_load_data = i_mem_rdata;
        endcase
    end

    assign w_halt_take = i_valid & i_halt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_RUN;
            r_alu_result <= '0;
            r_load_data  <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd_addr    <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (r_state == S_HALTED) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (i_flush) begin
            r_alu_result <= '0;
            r_load_data  <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd_addr    <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!i_stall) begin
            r_alu_result <= i_alu_result;
            r_load_data  <= w_load_data;
            r_mem_to_reg <= i_mem_to_reg;
            r_reg_write  <= i_reg_write & i_valid & ~w_misaligned & ~w_halt_take;
            r_rd_addr    <= i_rd_addr;
            r_valid      <= i_valid;
            r_misaligned <= w_misaligned;
            if (w_halt_take) begin
                r_state <= S_HALTED;
            end
        end
    end

    assign o_alu_result = r_alu_result;
    assign o_load_data  = r_load_data;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_reg_write  = r_reg_write;
    assign o_rd_addr    = r_rd_addr;
    assign o_valid      = r_valid;
    assign o_misaligned = r_misaligned;
    assign o_halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: load alignment, misalignment, stall/flush,
// halt stickiness and back-to-back capture.
module tb_mem_wb_reg;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stall, i_flush, i_valid;
    logic [31:0] i_alu_result, i_mem_rdata;
    logic        i_mem_to_reg, i_reg_write;
    logic [4:0]  i_rd_addr;
    logic [1:0]  i_load_size;
    logic        i_load_unsigned, i_halt;
    logic [31:0] o_alu_result, o_load_data;
    logic        o_mem_to_reg, o_reg_write, o_valid, o_misaligned, o_halted;
    logic [4:0]  o_rd_addr;

    int n_total = 0;
    int n_bad   = 0;

    mem_wb_reg #(.NB_DATA(32), .NB_REG_ADDR(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata),
        .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_rd_addr(i_rd_addr),
        .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned), .i_halt(i_halt),
        .o_alu_result(o_alu_result), .o_load_data(o_load_data),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_rd_addr(o_rd_addr),
        .o_valid(o_valid), .o_misaligned(o_misaligned), .o_halted(o_halted)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic m2r,
                         input logic rw, input logic [4:0] rd, input logic [1:0] sz,
                         input logic uns, input logic hlt);
        i_valid = v; i_alu_result = alu; i_mem_to_reg = m2r; i_reg_write = rw;
        i_rd_addr = rd; i_load_size = sz; i_load_unsigned = uns; i_halt = hlt;
    endtask

    initial begin
        i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_mem_rdata = 32'h80F1_7F82;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd9, 2'b10, 1'b0, 1'b0);
        tick;
        chk("rst_alu",   o_alu_result, 32'h0);
        chk("rst_load",  o_load_data, 32'h0);
        chk("rst_rd",    {27'd0, o_rd_addr}, 32'h0);
        chk("rst_flags", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'h0);
        i_reset = 1'b0;

        drive(1'b1, 32'h0000_1000, 1'b1, 1'b1, 5'd4, 2'b00, 1'b0, 1'b0); tick;
        chk("ld_b_s_off0", o_load_data, 32'hFFFF_FF82);
        chk("ld_b_s_rw",   {31'd0, o_reg_write}, 32'd1);
        drive(1'b1, 32'h0000_1003, 1'b1, 1'b1, 5'd4, 2'b00, 1'b1, 1'b0); tick;
        chk("ld_b_u_off3", o_load_data, 32'h0000_0080);
        drive(1'b1, 32'h0000_1001, 1'b1, 1'b1, 5'd4, 2'b00, 1'b0, 1'b0); tick;
        chk("ld_b_s_off1", o_load_data, 32'h0000_007F);
        drive(1'b1, 32'h0000_1002, 1'b1, 1'b1, 5'd4, 2'b01, 1'b0, 1'b0); tick;
        chk("ld_h_s_off2", o_load_data, 32'hFFFF_80F1);
        chk("ld_h_s_rw",   {31'd0, o_reg_write}, 32'd1);
        drive(1'b1, 32'h0000_1000, 1'b1, 1'b1, 5'd4, 2'b01, 1'b1, 1'b0); tick;
        chk("ld_h_u_off0", o_load_data, 32'h0000_7F82);
        drive(1'b1, 32'h0000_1000, 1'b1, 1'b1, 5'd4, 2'b10, 1'b1, 1'b0); tick;
        chk("ld_w",      o_load_data, 32'h80F1_7F82);
        chk("ld_w_rw",   {31'd0, o_reg_write}, 32'd1);
        drive(1'b1, 32'h0000_1001, 1'b1, 1'b1, 5'd4, 2'b11, 1'b0, 1'b0); tick;
        chk("ld_w11",    o_load_data, 32'h80F1_7F82);
        chk("ld_w11_mis", {31'd0, o_misaligned}, 32'd0);

        drive(1'b1, 32'h0000_1003, 1'b1, 1'b1, 5'd4, 2'b01, 1'b0, 1'b0); tick;
        chk("mis_flag", {31'd0, o_misaligned}, 32'd1);
        chk("mis_rw",   {31'd0, o_reg_write}, 32'd0);
        chk("mis_data", o_load_data, 32'hFFFF_80F1);
        drive(1'b1, 32'h0000_1003, 1'b0, 1'b1, 5'd4, 2'b01, 1'b0, 1'b0); tick;
        chk("mis_alu_flag", {31'd0, o_misaligned}, 32'd0);
        chk("mis_alu_rw",   {31'd0, o_reg_write}, 32'd1);

        drive(1'b1, 32'h0000_1234, 1'b0, 1'b1, 5'd7, 2'b10, 1'b0, 1'b0); tick;
        chk("cap_alu", o_alu_result, 32'h0000_1234);
        chk("cap_rd",  {27'd0, o_rd_addr}, 32'd7);
        i_stall = 1'b1;
        drive(1'b1, 32'h0000_5555, 1'b1, 1'b0, 5'd12, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stl_alu", o_alu_result, 32'h0000_1234);
            chk("stl_ctl", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'b11000);
            chk("stl_rd",  {27'd0, o_rd_addr}, 32'd7);
        end
        i_flush = 1'b1; tick;
        chk("fl_ctl", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'd0);
        chk("fl_rd",  {27'd0, o_rd_addr}, 32'd0);
        chk("fl_alu", o_alu_result, 32'd0);
        chk("fl_ld",  o_load_data, 32'd0);
        i_stall = 1'b0; i_flush = 1'b0;

        drive(1'b1, 32'h0000_000A, 1'b0, 1'b1, 5'd1, 2'b10, 1'b0, 1'b0); tick;
        chk("b2b_alu", o_alu_result, 32'h0000_000A);
        chk("b2b_rd1", {27'd0, o_rd_addr}, 32'd1);
        chk("b2b_m2r0", {31'd0, o_mem_to_reg}, 32'd0);
        drive(1'b1, 32'h0000_2000, 1'b1, 1'b1, 5'd2, 2'b10, 1'b0, 1'b0); tick;
        chk("b2b_rd2",  {27'd0, o_rd_addr}, 32'd2);
        chk("b2b_ctl",  {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'b11100);
        chk("b2b_ld",   o_load_data, 32'h80F1_7F82);

        drive(1'b0, 32'h0000_0040, 1'b0, 1'b1, 5'd5, 2'b10, 1'b0, 1'b1); tick;
        chk("hlt_inv", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'd0);

        drive(1'b1, 32'h0000_0044, 1'b0, 1'b1, 5'd6, 2'b10, 1'b0, 1'b1); tick;
        chk("hlt_ctl", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'b10001);
        chk("hlt_rd",  {27'd0, o_rd_addr}, 32'd6);
        drive(1'b1, 32'h0000_0048, 1'b0, 1'b1, 5'd3, 2'b10, 1'b0, 1'b0); tick;
        chk("hltd_ctl", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'b00001);
        chk("hltd_rd",  {27'd0, o_rd_addr}, 32'd6);
        chk("hltd_alu", o_alu_result, 32'h0000_0044);
        i_flush = 1'b1; tick;
        chk("hltd_fl_alu", o_alu_result, 32'h0000_0044);
        chk("hltd_fl_halt", {31'd0, o_halted}, 32'd1);
        i_flush = 1'b0;
        i_reset = 1'b1; tick;
        chk("hltd_rst", {27'd0, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_halted}, 32'd0);
        chk("hltd_rst_alu", o_alu_result, 32'd0);
        i_reset = 1'b0;
        drive(1'b1, 32'h0000_0050, 1'b0, 1'b1, 5'd8, 2'b10, 1'b0, 1'b0); tick;
        chk("post_rst_rw", {31'd0, o_reg_write}, 32'd1);
        chk("post_rst_rd", {27'd0, o_rd_addr}, 32'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
